lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write-only bus controller: one byte per request, with setup/enable/hold/exec timing.
// Define LCD_INIT_SEQ_EN to add the power-up wait and built-in init sequence (0x38, 0x0C, 0x06, 0x01).
module lcd_ctrl #(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_LONG  = 80000,
    parameter int T_PWRUP = 800000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXT = imax(imax(imax(T_SETUP, T_EN), imax(T_HOLD, T_EXEC)), imax(T_LONG, T_PWRUP));
    localparam int CW   = ($clog2(MAXT + 1) > 20) ? $clog2(MAXT + 1) : 20;

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d;
    logic            en_q;
    logic            done_q, done_d;
    logic            is_long;

`ifdef LCD_INIT_SEQ_EN
    logic [1:0] step_q, step_d;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction
`endif

    // Clear and home need the long execution time; everything else uses T_EXEC.
    assign is_long = !rs_q && (data_q == 8'h01 || data_q == 8'h02);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
`ifdef LCD_INIT_SEQ_EN
        done_d  = done_q;
        step_d  = step_q;
`else
        done_d  = 1'b1;
`endif
        case (state_q)
`ifdef LCD_INIT_SEQ_EN
            // Counter starts cleared by reset, so the power-up wait counts up to T_PWRUP-1.
            PWRUP: begin
                if (cnt_q == CW'(T_PWRUP - 1)) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            INIT: begin
                data_d  = init_cmd(step_q);
                rs_d    = 1'b0;
                cnt_d   = CW'(T_SETUP - 1);
                state_d = SETUP;
            end
`endif
            IDLE: begin
                if (req_valid && req_ready) begin
                    data_d  = req_data;
                    rs_d    = req_rs;
                    cnt_d   = CW'(T_SETUP - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CW'(T_EN - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CW'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = WAIT;
                    cnt_d   = is_long ? CW'(T_LONG - 1) : CW'(T_EXEC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
`ifdef LCD_INIT_SEQ_EN
                    if (done_q) begin
                        state_d = IDLE;
                    end else if (step_q == 2'd3) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        step_d  = step_q + 2'd1;
                        state_d = INIT;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef LCD_INIT_SEQ_EN
            state_q <= PWRUP;
            step_q  <= 2'd0;
`else
            state_q <= IDLE;
`endif
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
`ifdef LCD_INIT_SEQ_EN
            step_q  <= step_d;
`endif
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            // Registered so the strobe is glitch-free on the pin.
            en_q    <= (state_d == PULSE);
            done_q  <= done_d;
        end
    end

    assign req_ready = (state_q == IDLE) && done_q;
    assign init_done = done_q;
    assign lcd_data  = data_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = en_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing (SETUP 2, EN 4, HOLD 2, EXEC 10, LONG 50, PWRUP 20).
// Cycle c below is the value seen at the c-th falling edge after the acceptance (or reset-release) edge.
module tb_lcd_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_SETUP(2), .T_EN(4), .T_HOLD(2), .T_EXEC(10), .T_LONG(50), .T_PWRUP(20)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
        .req_ready(req_ready), .init_done(init_done),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", lcd_en); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", lcd_data); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b want 0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", lcd_rw); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reset_release_done: got %b want 1", init_done); end
    endtask

    // One write; junk req_valid is raised while busy and req_data/req_rs are scrambled after capture.
    task automatic test_single(input logic rs, input logic [7:0] d, input int exp_ready, input string nm);
        int en_first = -1, en_last = -1, en_cnt = 0, pulses = 0, rdy = -1;
        logic prev_en = 1'b0;
        logic [7:0] d1 = 8'h00;
        logic rs1 = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_pre: got %b want 1", nm, req_ready); end
        req_valid = 1'b1; req_rs = rs; req_data = d;
        @(posedge clk);
        #1 req_valid = 1'b0; req_data = ~d; req_rs = ~rs;
        for (int c = 1; c <= 100 && rdy < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin d1 = lcd_data; rs1 = lcd_rs; end
            if (lcd_en === 1'b1) begin
                if (!prev_en) pulses++;
                if (en_first < 0) en_first = c;
                en_last = c;
                en_cnt++;
            end
            prev_en = (lcd_en === 1'b1);
            if (req_ready === 1'b1) rdy = c;
            if (c == 5) begin req_valid = 1'b1; req_data = 8'hAA; end
            if (c == 9) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        checks++; if (d1 !== d) begin errors++; $display("FAIL %s_data_c1: got %h want %h", nm, d1, d); end
        checks++; if (rs1 !== rs) begin errors++; $display("FAIL %s_rs_c1: got %b want %b", nm, rs1, rs); end
        checks++; if (en_first != 3) begin errors++; $display("FAIL %s_en_first: got %0d want 3", nm, en_first); end
        checks++; if (en_last != 6) begin errors++; $display("FAIL %s_en_last: got %0d want 6", nm, en_last); end
        checks++; if (en_cnt != 4 || pulses != 1) begin errors++; $display("FAIL %s_en_shape: got %0d cycles %0d pulses want 4 1", nm, en_cnt, pulses); end
        checks++; if (rdy != exp_ready) begin errors++; $display("FAIL %s_ready_cycle: got %0d want %0d", nm, rdy, exp_ready); end
        checks++; if (lcd_data !== d || lcd_rs !== rs) begin errors++; $display("FAIL %s_idle_hold: got %h/%b want %h/%b", nm, lcd_data, lcd_rs, d, rs); end
        checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL %s_rw: got %b want 0", nm, lcd_rw); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3] = '{8'h48, 8'h49, 8'h21};
        int starts[$];
        logic [7:0] dats[$];
        int idx = 0;
        logic prev_rdy = 1'b1, prev_en = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_pre: got %b want 1", req_ready); end
        req_valid = 1'b1; req_rs = 1'b1; req_data = bytes[0];
        @(posedge clk);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (lcd_en === 1'b1 && !prev_en) begin starts.push_back(c); dats.push_back(lcd_data); end
            prev_en = (lcd_en === 1'b1);
            if (prev_rdy && req_valid) begin
                idx++;
                if (idx < 3) req_data = bytes[idx];
                else req_valid = 1'b0;
            end
            prev_rdy = (req_ready === 1'b1);
        end
        req_valid = 1'b0;
        checks++; if (starts.size() != 3) begin errors++; $display("FAIL b2b_pulse_count: got %0d want 3", starts.size()); end
        for (int i = 0; i < 3 && i < starts.size(); i++) begin
            checks++; if (starts[i] != 3 + 19 * i) begin errors++; $display("FAIL b2b_start%0d: got %0d want %0d", i, starts[i], 3 + 19 * i); end
            checks++; if (dats[i] !== bytes[i]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, dats[i], bytes[i]); end
        end
    endtask

    task automatic test_reset_mid;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_pre: got %b want 1", req_ready); end
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (lcd_en !== 1'b1) begin errors++; $display("FAIL rstmid_en_c4: got %b want 1", lcd_en); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL rstmid_en: got %b want 0", lcd_en); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", lcd_data); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL rstmid_rs: got %b want 0", lcd_rs); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_in_rst: got %b want 0", req_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b want 1", req_ready); end
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL rstmid_en_after: got %b want 0", lcd_en); end
    endtask

`ifdef LCD_INIT_SEQ_EN
    task automatic test_init;
        int exp_start [4] = '{23, 42, 61, 80};
        logic [7:0] exp_cmd [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
        int starts[$];
        logic [7:0] dats[$];
        logic rss[$];
        int en_last = -1, done_c = -1, rdy_c = -1;
        logic prev_en = 1'b0;
        rst = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (init_done !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL init_rst: got done=%b ready=%b want 0 0", init_done, req_ready); end
        rst = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL init_done_early: got %b want 0", init_done); end
            end
            if (lcd_en === 1'b1) begin
                if (!prev_en) begin starts.push_back(c); dats.push_back(lcd_data); rss.push_back(lcd_rs); end
                en_last = c;
            end
            prev_en = (lcd_en === 1'b1);
            if (init_done === 1'b1 && done_c < 0) done_c = c;
            if (req_ready === 1'b1 && rdy_c < 0) rdy_c = c;
            if (c == 10 || c == 100) begin req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55; end
            if (c == 15 || c == 105) req_valid = 1'b0;
        end
        checks++; if (starts.size() != 4) begin errors++; $display("FAIL init_pulse_count: got %0d want 4", starts.size()); end
        for (int i = 0; i < 4 && i < starts.size(); i++) begin
            checks++; if (starts[i] != exp_start[i]) begin errors++; $display("FAIL init_start%0d: got %0d want %0d", i, starts[i], exp_start[i]); end
            checks++; if (dats[i] !== exp_cmd[i] || rss[i] !== 1'b0) begin errors++; $display("FAIL init_cmd%0d: got %h/%b want %h/0", i, dats[i], rss[i], exp_cmd[i]); end
        end
        checks++; if (en_last != 83) begin errors++; $display("FAIL init_last_en: got %0d want 83", en_last); end
        checks++; if (done_c != 136) begin errors++; $display("FAIL init_done_cycle: got %0d want 136", done_c); end
        checks++; if (rdy_c != 136) begin errors++; $display("FAIL init_ready_cycle: got %0d want 136", rdy_c); end
    endtask
`endif

    initial begin
`ifdef LCD_INIT_SEQ_EN
        test_init();
        test_single(1'b1, 8'h41, 19, "post_init");
`else
        test_reset();
        test_single(1'b1, 8'h41, 19, "data41");
        test_single(1'b0, 8'h01, 59, "clear");
        test_single(1'b0, 8'h02, 59, "home");
        test_single(1'b1, 8'h01, 19, "data01");
        test_single(1'b0, 8'h38, 19, "cmd38");
        test_back_to_back();
        test_reset_mid();
        test_single(1'b1, 8'h5A, 19, "after_rst");
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
